data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
Shares the single-port 16x16 data memory between the pipeline memory stage (CPU port) and a debug/loader port (DBG port) for program/data preload and inspection. It sequences each access as a fixed 3-cycle transaction (latch, access, respond) and stalls the pipeline while a CPU access is outstanding. CPU has fixed priority; a wait counter prevents DBG starvation.

Parameters:
DATA_W, 16, data word width
ADDR_W, 4, word address width (2**ADDR_W words)
MAX_WAIT, 4, consecutive CPU grants tolerated while DBG waits; range 1..15

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU store data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  CPU load data, valid with cpu_ack, held until next CPU load ack
cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata  same as CPU set, DBG port
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset (async, immediate): state IDLE; owner, wait_cnt, latched addr/we/wdata, cpu_rdata, dbg_rdata = 0; all acks, mem_en, mem_we = 0.
- States: IDLE, ACCESS, RESP.
- IDLE: no req -> stay. Any req -> pick winner, latch winner's we/addr/wdata and owner, go ACCESS.
- Winner: only one req -> that port. Both -> DBG if wait_cnt == MAX_WAIT, else CPU.
- wait_cnt at each IDLE decision: CPU granted with dbg_req=1 -> +1 (saturate at MAX_WAIT); DBG granted or dbg_req=0 -> 0.
- ACCESS: mem_en=1, mem_we=latched we, mem_addr/mem_wdata from latch (registered, stable whole cycle). Always -> RESP.
- RESP: owner's ack=1 for exactly this cycle; on read, owner's rdata <= mem_rdata (visible with ack, registered capture on same edge as entry into RESP is not allowed; drive rdata output from mem_rdata muxed into holding reg so it is valid during ack). Non-owner's rdata unchanged. Always -> IDLE.
- Latency: req seen in IDLE at cycle N -> ACCESS N+1 -> ack at N+2. Throughput 1 transaction per 3 cycles; no RESP->ACCESS shortcut.
- mem_en/mem_we = 0 in IDLE and RESP; addresses/data outputs hold last latched value.
- Stores: ack issued in RESP; write committed at end of ACCESS.
- Req dropped after latch: transaction completes, ack still pulses. Req changes after latch: ignored (latched values used).
- Req still high in ack cycle: treated as a new request at the following IDLE.
- rst during ACCESS: mem_we drops immediately; write not guaranteed; no ack issued. rst during RESP: ack dropped, rdata regs cleared.
- Address full range 0..2**ADDR_W-1, no wrap/check needed.

Decomposition:
- Package data_mem_arb_pkg: state encoding (IDLE=0, ACCESS=1, RESP=2), owner encoding (OWN_CPU=0, OWN_DBG=1), default widths.
- One sub-module: mem_arb_prio (winner select + saturating wait_cnt); FSM, latches, memory drive in top.

Test Plan:
- CPU store addr 2 data 16'h0010, then CPU load addr 2 -> store ack at cycle+2, load cpu_ack with cpu_rdata=16'h0010; mem_we=1 only in store ACCESS cycle.
- DBG store addr 7 data 16'hA5A5 with CPU idle -> dbg_ack after 2 cycles; later CPU load addr 7 -> cpu_rdata=16'hA5A5, dbg_rdata unchanged.
- CPU and DBG requesting continuously, MAX_WAIT=4 -> grant order CPU,CPU,CPU,CPU,DBG, repeating; cpu_stall high in every non-ack cycle.
- Simultaneous first request, wait_cnt=0 -> CPU wins; dbg_ack only after cpu_ack plus 3 cycles.
- rst asserted mid-ACCESS of CPU store addr 3 -> all outputs 0 immediately, no cpu_ack, state IDLE after release; new request serviced normally.
- CPU drops req one cycle after latch (load addr 5) -> cpu_ack still pulses with mem word 5; cpu_stall=0 while req low.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types and default sizes for the data memory arbiter.
package data_mem_arb_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int ADDR_W_DEF   = 4;
  localparam int MAX_WAIT_DEF = 4;
  // Wide enough for the largest supported MAX_WAIT (15).
  localparam int WAIT_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between CPU and DBG with a saturating DBG starvation counter.
module mem_arb_prio
  import data_mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   decide,
  input  logic   cpu_req,
  input  logic   dbg_req,
  output owner_t winner
);

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  // CPU wins ties unless DBG has waited MAX_WAIT consecutive CPU grants.
  always_comb begin
    winner = OWN_CPU;
    if (dbg_req && (!cpu_req || wait_cnt == WAIT_LIM)) winner = OWN_DBG;
  end

  // Count CPU grants made while DBG was waiting; any other IDLE decision clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (decide) begin
      if (cpu_req && dbg_req && winner == OWN_CPU) begin
        if (wait_cnt != WAIT_LIM) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-port data memory between the CPU memory stage and a debug port.
// Each access is a fixed latch/access/respond sequence; CPU is stalled until ack.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state, state_nxt;
  owner_t            owner, winner;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic              any_req, resp_rd, cpu_rd_live, dbg_rd_live;

  assign any_req = cpu_req | dbg_req;

  mem_arb_prio #(
    .MAX_WAIT(MAX_WAIT)
  ) u_prio (
    .clk     (clk),
    .rst     (rst),
    .decide  (state == IDLE),
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .winner  (winner)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus memory strobes and acks decoded from the registered state.
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    cpu_ack   = 1'b0;
    dbg_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        state_nxt = RESP;
      end
      RESP: begin
        cpu_ack   = (owner == OWN_CPU);
        dbg_ack   = (owner == OWN_DBG);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winning request at the IDLE decision; later req changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_CPU;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == IDLE && any_req) begin
      owner     <= winner;
      lat_we    <= (winner == OWN_DBG) ? dbg_we    : cpu_we;
      lat_addr  <= (winner == OWN_DBG) ? dbg_addr  : cpu_addr;
      lat_wdata <= (winner == OWN_DBG) ? dbg_wdata : cpu_wdata;
    end
  end

  assign resp_rd     = (state == RESP) && !lat_we;
  assign cpu_rd_live = resp_rd && (owner == OWN_CPU);
  assign dbg_rd_live = resp_rd && (owner == OWN_DBG);

  // Holding registers capture the read word as RESP ends; during RESP the live
  // memory word is forwarded so rdata is already valid alongside the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (cpu_rd_live) cpu_rdata_q <= mem_rdata;
      if (dbg_rd_live) dbg_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rdata = cpu_rd_live ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata = dbg_rd_live ? mem_rdata : dbg_rdata_q;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: scoreboard of expected acks plus per-scenario checks.
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [3:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_wdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        dbg;
    logic        we;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  logic [15:0] ref_mem [16];
  logic [15:0] mem     [16];

  data_mem_arbiter #(
    .DATA_W   (16),
    .ADDR_W   (4),
    .MAX_WAIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous single-port memory: write at the edge, read data one cycle later.
  always @(posedge clk) begin
    if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  // Scoreboard monitor: every ack must match the next expected transaction.
  always @(negedge clk) begin
    if (cpu_ack || dbg_ack) begin
      total++;
      if (cpu_ack && dbg_ack) begin
        bad++;
        $display("FAIL sb_dual_ack: got cpu_ack=1 dbg_ack=1, want one ack");
      end else if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_ack: got ack cpu=%0b dbg=%0b, want none", cpu_ack, dbg_ack);
      end else begin
        sb_e = sb_q.pop_front();
        if (dbg_ack !== sb_e.dbg) begin
          bad++;
          $display("FAIL sb_port: got dbg_ack=%0b, want dbg=%0b", dbg_ack, sb_e.dbg);
        end else if (!sb_e.we) begin
          total++;
          if ((sb_e.dbg ? dbg_rdata : cpu_rdata) !== sb_e.data) begin
            bad++;
            $display("FAIL sb_rdata: port dbg=%0b got %h want %h",
                     sb_e.dbg, sb_e.dbg ? dbg_rdata : cpu_rdata, sb_e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic dbg, input logic we, input logic [3:0] addr,
                          input logic [15:0] data);
    exp_t e;
    e.dbg = dbg;
    e.we  = we;
    if (we) begin
      ref_mem[addr] = data;
      e.data = data;
    end else begin
      e.data = ref_mem[addr];
    end
    sb_q.push_back(e);
  endtask

  task automatic drive_cpu(input logic we, input logic [3:0] addr, input logic [15:0] data);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
  endtask

  task automatic drive_dbg(input logic we, input logic [3:0] addr, input logic [15:0] data);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = data;
  endtask

  // Advance negedges until the selected ack is seen or the budget expires.
  task automatic wait_ack(input logic dbg, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(dbg ? dbg_ack : cpu_ack) && cyc < 20);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({cpu_ack, dbg_ack, mem_en, mem_we, cpu_stall} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got ack/en/we/stall=%b want 00000",
               {cpu_ack, dbg_ack, mem_en, mem_we, cpu_stall});
    end
    total++;
    if (cpu_rdata !== 16'h0 || dbg_rdata !== 16'h0) begin
      bad++;
      $display("FAIL reset_rdata: got cpu=%h dbg=%h want 0000", cpu_rdata, dbg_rdata);
    end
    total++;
    if (mem_addr !== 4'h0 || mem_wdata !== 16'h0) begin
      bad++;
      $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (mem_en !== 1'b0 || cpu_ack !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got mem_en=%b cpu_ack=%b want 0", mem_en, cpu_ack);
    end
  endtask

  task automatic test_cpu_store_load();
    int cyc;
    push_exp(1'b0, 1'b1, 4'd2, 16'h0010);
    drive_cpu(1'b1, 4'd2, 16'h0010);
    @(negedge clk);
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1) begin
      bad++;
      $display("FAIL store_access: got en=%b we=%b want 1 1", mem_en, mem_we);
    end
    total++;
    if (mem_addr !== 4'd2 || mem_wdata !== 16'h0010) begin
      bad++;
      $display("FAIL store_bus: got addr=%h data=%h want 2 0010", mem_addr, mem_wdata);
    end
    total++;
    if (cpu_stall !== 1'b1 || cpu_ack !== 1'b0) begin
      bad++;
      $display("FAIL store_stall: got stall=%b ack=%b want 1 0", cpu_stall, cpu_ack);
    end
    @(negedge clk);
    total++;
    if (cpu_ack !== 1'b1 || mem_we !== 1'b0 || mem_en !== 1'b0) begin
      bad++;
      $display("FAIL store_resp: got ack=%b we=%b en=%b want 1 0 0", cpu_ack, mem_we, mem_en);
    end
    total++;
    if (cpu_stall !== 1'b0) begin
      bad++;
      $display("FAIL store_stall_ack: got %b want 0", cpu_stall);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    push_exp(1'b0, 1'b0, 4'd2, 16'h0);
    drive_cpu(1'b0, 4'd2, 16'h0);
    @(negedge clk);
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL load_access: got en=%b we=%b want 1 0", mem_en, mem_we);
    end
    cyc = 1;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cpu_ack && cyc < 20);
    total++;
    if (cyc != 2) begin
      bad++;
      $display("FAIL load_latency: got %0d cycles want 2", cyc);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    total++;
    if (cpu_rdata !== 16'h0010) begin
      bad++;
      $display("FAIL load_hold: got %h want 0010", cpu_rdata);
    end
  endtask

  task automatic test_dbg_access();
    int cyc;
    push_exp(1'b1, 1'b1, 4'd7, 16'hA5A5);
    drive_dbg(1'b1, 4'd7, 16'hA5A5);
    wait_ack(1'b1, cyc);
    total++;
    if (cyc != 2) begin
      bad++;
      $display("FAIL dbg_store_latency: got %0d want 2", cyc);
    end
    dbg_req = 1'b0;
    @(negedge clk);
    push_exp(1'b1, 1'b0, 4'd2, 16'h0);
    drive_dbg(1'b0, 4'd2, 16'h0);
    wait_ack(1'b1, cyc);
    total++;
    if (cyc != 2) begin
      bad++;
      $display("FAIL dbg_load_latency: got %0d want 2", cyc);
    end
    total++;
    if (cpu_rdata !== 16'h0010) begin
      bad++;
      $display("FAIL dbg_load_cpu_rdata: got %h want 0010", cpu_rdata);
    end
    dbg_req = 1'b0;
    @(negedge clk);
    push_exp(1'b0, 1'b0, 4'd7, 16'h0);
    drive_cpu(1'b0, 4'd7, 16'h0);
    wait_ack(1'b0, cyc);
    cpu_req = 1'b0;
    total++;
    if (cyc != 2) begin
      bad++;
      $display("FAIL cpu_load7_latency: got %0d want 2", cyc);
    end
    @(negedge clk);
    total++;
    if (cpu_rdata !== 16'hA5A5 || dbg_rdata !== 16'h0010) begin
      bad++;
      $display("FAIL cpu_load7_hold: got cpu=%h dbg=%h want A5A5 0010", cpu_rdata, dbg_rdata);
    end
  endtask

  task automatic test_simultaneous();
    int cpu_at = 0;
    int dbg_at = 0;
    push_exp(1'b0, 1'b1, 4'd8, 16'h1111);
    push_exp(1'b1, 1'b0, 4'd7, 16'h0);
    drive_cpu(1'b1, 4'd8, 16'h1111);
    drive_dbg(1'b0, 4'd7, 16'h0);
    for (int c = 1; c <= 20 && dbg_at == 0; c++) begin
      @(negedge clk);
      if (cpu_req && !cpu_ack) begin
        total++;
        if (cpu_stall !== 1'b1) begin
          bad++;
          $display("FAIL sim_stall: cycle %0d got %b want 1", c, cpu_stall);
        end
      end
      if (cpu_ack && cpu_at == 0) begin
        cpu_at = c;
        cpu_req = 1'b0;
      end
      if (dbg_ack) begin
        dbg_at = c;
        dbg_req = 1'b0;
      end
    end
    total++;
    if (cpu_at != 2) begin
      bad++;
      $display("FAIL sim_cpu_first: got cpu ack cycle %0d want 2", cpu_at);
    end
    total++;
    if (dbg_at != 5) begin
      bad++;
      $display("FAIL sim_dbg_after: got dbg ack cycle %0d want 5", dbg_at);
    end
    dbg_req = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic exp_cpu, exp_dbg;
    int   k;
    for (int i = 0; i < 15; i++) begin
      if (i % 5 == 4) push_exp(1'b1, 1'b0, 4'd8, 16'h0);
      else            push_exp(1'b0, 1'b0, 4'd2, 16'h0);
    end
    drive_cpu(1'b0, 4'd2, 16'h0);
    drive_dbg(1'b0, 4'd8, 16'h0);
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      k = (c - 2) / 3;
      exp_cpu = (c >= 2) && ((c - 2) % 3 == 0) && (k % 5 != 4);
      exp_dbg = (c >= 2) && ((c - 2) % 3 == 0) && (k % 5 == 4);
      total++;
      if (cpu_ack !== exp_cpu || dbg_ack !== exp_dbg) begin
        bad++;
        $display("FAIL b2b_grant: cycle %0d got cpu=%b dbg=%b want cpu=%b dbg=%b",
                 c, cpu_ack, dbg_ack, exp_cpu, exp_dbg);
      end
      total++;
      if (cpu_stall !== !exp_cpu) begin
        bad++;
        $display("FAIL b2b_stall: cycle %0d got %b want %b", c, cpu_stall, !exp_cpu);
      end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    int cyc;
    drive_cpu(1'b1, 4'd3, 16'h3333);
    @(negedge clk);
    total++;
    if (mem_we !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_access: got mem_we=%b want 1", mem_we);
    end
    #2;
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    total++;
    if ({cpu_ack, dbg_ack, mem_en, mem_we, cpu_stall} !== 5'b0) begin
      bad++;
      $display("FAIL rst_mid_ctrl: got ack/en/we/stall=%b want 00000",
               {cpu_ack, dbg_ack, mem_en, mem_we, cpu_stall});
    end
    total++;
    if (cpu_rdata !== 16'h0 || dbg_rdata !== 16'h0 || mem_addr !== 4'h0 || mem_wdata !== 16'h0) begin
      bad++;
      $display("FAIL rst_mid_data: got cpu=%h dbg=%h addr=%h wdata=%h want 0",
               cpu_rdata, dbg_rdata, mem_addr, mem_wdata);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (cpu_ack !== 1'b0 || mem_en !== 1'b0) begin
        bad++;
        $display("FAIL rst_no_ack: cycle %0d got ack=%b en=%b want 0 0", c, cpu_ack, mem_en);
      end
    end
    push_exp(1'b0, 1'b0, 4'd7, 16'h0);
    drive_cpu(1'b0, 4'd7, 16'h0);
    wait_ack(1'b0, cyc);
    cpu_req = 1'b0;
    total++;
    if (cyc != 2) begin
      bad++;
      $display("FAIL rst_recover_latency: got %0d want 2", cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_drop_req();
    int cyc;
    push_exp(1'b0, 1'b1, 4'd5, 16'h5A5A);
    drive_cpu(1'b1, 4'd5, 16'h5A5A);
    wait_ack(1'b0, cyc);
    cpu_req = 1'b0;
    total++;
    if (cyc != 2) begin
      bad++;
      $display("FAIL drop_store_latency: got %0d want 2", cyc);
    end
    @(negedge clk);
    push_exp(1'b0, 1'b0, 4'd5, 16'h0);
    drive_cpu(1'b0, 4'd5, 16'h0);
    @(negedge clk);
    total++;
    if (cpu_stall !== 1'b1) begin
      bad++;
      $display("FAIL drop_stall_before: got %b want 1", cpu_stall);
    end
    cpu_req  = 1'b0;
    cpu_addr = 4'd9;
    #1;
    total++;
    if (cpu_stall !== 1'b0) begin
      bad++;
      $display("FAIL drop_stall_low: got %b want 0", cpu_stall);
    end
    @(negedge clk);
    total++;
    if (cpu_ack !== 1'b1 || cpu_stall !== 1'b0) begin
      bad++;
      $display("FAIL drop_ack: got ack=%b stall=%b want 1 0", cpu_ack, cpu_stall);
    end
    @(negedge clk);
    total++;
    if (cpu_ack !== 1'b0 || cpu_rdata !== 16'h5A5A) begin
      bad++;
      $display("FAIL drop_after: got ack=%b rdata=%h want 0 5A5A", cpu_ack, cpu_rdata);
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0;
    test_reset();
    test_cpu_store_load();
    test_dbg_access();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_access();
    test_drop_req();
    repeat (3) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
